// File: rtl/alu_pkg.sv
// Shared ALU op codes and driver FSM state encodings.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Golden combinational ALU used to cross-check the external ALU.
// Latency: combinational. Backpressure: none.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        control,
  output logic [DATA_W-1:0] result,
  output logic              zflag
);

  always_comb begin
    result = '0;
    case (control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
    zflag = (result == '0);
  end

endmodule

// File: rtl/alu_op_driver.sv
// Registers valid/ready op requests onto a combinational ALU and returns tagged results.
// Latency: handshake cycle + 2 edges to rsp_valid; peak 1 op per 2 cycles.
// Backpressure: rsp_* held while !rsp_ready; a new request is only taken as the response drains.
// Optional ALU cross-check built when ALU_OP_CHECK_EN is defined.
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [1:0]        req_op,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zflag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zflag,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  op_count,
  output logic              busy
`ifdef ALU_OP_CHECK_EN
  ,
  output logic              chk_err,
  output logic [CNT_W-1:0]  chk_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [TAG_W-1:0]  tag_q;
  logic              accept;

  // In RESP the slot frees in the same cycle the response is taken.
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= ALU_ADD;
      tag_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zflag   <= 1'b0;
      rsp_tag     <= '0;
      op_count    <= '0;
    end else begin
      if (accept) begin
        alu_a       <= req_a;
        alu_b       <= req_b;
        alu_control <= req_op;
        tag_q       <= req_tag;
      end
      case (state_q)
        ST_IDLE: begin
          if (req_valid) state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_zflag  <= alu_zflag;
          rsp_tag    <= tag_q;
          rsp_valid  <= 1'b1;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_ONE;
            state_q   <= req_valid ? ST_EXEC : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_OP_CHECK_EN
  logic [DATA_W-1:0] ref_result;
  logic              ref_zflag;

  alu_ref_model #(.DATA_W(DATA_W)) u_ref (
    .a       (alu_a),
    .b       (alu_b),
    .control (alu_control),
    .result  (ref_result),
    .zflag   (ref_zflag)
  );

  // Compared only while the ALU inputs are settled for a live op.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err <= 1'b0;
      chk_cnt <= '0;
    end else if ((state_q == ST_EXEC) &&
                 ((alu_result != ref_result) || (alu_zflag != ref_zflag))) begin
      chk_err <= 1'b1;
      if (chk_cnt != {CNT_W{1'b1}}) chk_cnt <= chk_cnt + CNT_ONE;
    end
  end
`endif

endmodule
